// File: rtl/cpu_load_store_queue_pkg.sv
// Shared definitions for the load/store queue.
// Holds the memory-op type codes carried from execute, the head FSM state
// codes, and small decode helpers used by the queue top.
package cpu_load_store_queue_pkg;

  localparam int LS_SEL_WIDTH  = 3;
  localparam int LS_TYPE_WIDTH = LS_SEL_WIDTH + 1;

  typedef enum logic [LS_SEL_WIDTH:0] {
    LS_TYPE_NONE = 4'd0,
    LS_TYPE_LB   = 4'd1,
    LS_TYPE_LH   = 4'd2,
    LS_TYPE_LW   = 4'd3,
    LS_TYPE_LBU  = 4'd4,
    LS_TYPE_LHU  = 4'd5,
    LS_TYPE_SB   = 4'd6,
    LS_TYPE_SH   = 4'd7,
    LS_TYPE_SW   = 4'd8
  } ls_type_e;

  typedef enum logic [1:0] {
    LSQ_IDLE     = 2'd0,
    LSQ_REQ      = 2'd1,
    LSQ_WAIT_RSP = 2'd2
  } lsq_state_e;

  function automatic logic is_load(input logic [LS_SEL_WIDTH:0] ls_type);
    case (ls_type)
      LS_TYPE_LB, LS_TYPE_LH, LS_TYPE_LW, LS_TYPE_LBU, LS_TYPE_LHU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [LS_SEL_WIDTH:0] ls_type);
    case (ls_type)
      LS_TYPE_SB, LS_TYPE_SH, LS_TYPE_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte-aligned one.
  function automatic logic is_misaligned(input logic [LS_SEL_WIDTH:0] ls_type,
                                         input logic [1:0] addr_lo);
    case (ls_type)
      LS_TYPE_LH, LS_TYPE_LHU, LS_TYPE_SH: return addr_lo[0];
      LS_TYPE_LW, LS_TYPE_SW:              return |addr_lo;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_load_store_queue_if.sv
// Data-memory request/response bus used by the load/store queue.
// master: the queue (drives requests, receives responses).
// slave : the data memory.
//   req_valid/req_ready  request handshake
//   write                1 = store
//   addr                 word-aligned byte address
//   wdata/wstrb          lane-aligned store data and byte strobes
//   rsp_valid/rsp_data   load response (raw word)
interface cpu_load_store_queue_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            write;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req_valid, write, addr, wdata, wstrb,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, write, addr, wdata, wstrb,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/cpu_load_store_queue_fifo.sv
// cpu_sync_fifo: in-order storage for the load/store queue.
// Ports:
//   i_Clock, i_Reset      clock, async active-high reset (pointers/count only)
//   push, push_data       write one entry (caller guarantees not full)
//   pop                   drop the head entry (caller guarantees not empty)
//   head_data             oldest entry
//   count                 number of valid entries (0..DEPTH)
//   all_data, slot_valid  every storage slot flattened, plus which hold live entries
module cpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH*WIDTH-1:0]   all_data,
  output logic [DEPTH-1:0]         slot_valid
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem_q[rd_ptr];

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] offset;
    assign offset                        = PTR_W'(i) - rd_ptr;
    assign slot_valid[i]                 = {1'b0, offset} < count;
    assign all_data[i*WIDTH +: WIDTH]    = mem_q[i];
  end

endmodule

// File: rtl/cpu_load_store_queue.sv
// cpu_load_store_queue: memory/writeback stage between execute and data memory.
// Entries from execute are queued in order; only the head is processed.
// ALU ops retire immediately, misaligned accesses are dropped with a pulse,
// loads/stores go through the valid/ready memory bus.
// Ports:
//   i_Clock, i_Reset            clock, async active-high reset
//   i_Ex_*/o_Ex_Ready           entry from execute, push = valid & ready
//   i_Rs_1, i_Rs_2              decode sources for the load-use check
//   o_Load_Use_Stall            comb, a pending load writes i_Rs_1/i_Rs_2
//   mem                         data-memory bus (master side)
//   o_Wb_Enable/Addr/Data       registered regfile write
//   o_Misaligned                one-cycle pulse for a dropped access
//   o_Empty                     nothing queued and no writeback pending
// Latency from push edge N: ALU writeback visible in cycle N+2; a load with
// an always-ready memory and 1-cycle response requests in N+1, gets its
// response in N+2 and writes back in N+3.
module cpu_load_store_queue
  import cpu_load_store_queue_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 2
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Ex_Valid,
  output logic                      o_Ex_Ready,
  input  logic [LS_SEL_WIDTH:0]     i_Ex_Ls_Type,
  input  logic [XLEN-1:0]           i_Ex_Addr,
  input  logic [XLEN-1:0]           i_Ex_Store_Data,
  input  logic [XLEN-1:0]           i_Ex_Reg_Data,
  input  logic [REG_ADDR_WIDTH-1:0] i_Ex_Reg_Addr,
  input  logic                      i_Ex_Reg_Write,
  input  logic [REG_ADDR_WIDTH-1:0] i_Rs_1,
  input  logic [REG_ADDR_WIDTH-1:0] i_Rs_2,
  output logic                      o_Load_Use_Stall,
  cpu_load_store_queue_if.master    mem,
  output logic                      o_Wb_Enable,
  output logic [REG_ADDR_WIDTH-1:0] o_Wb_Addr,
  output logic [XLEN-1:0]           o_Wb_Data,
  output logic                      o_Misaligned,
  output logic                      o_Empty
);

  typedef struct packed {
    logic [LS_SEL_WIDTH:0]     ls_type;
    logic [XLEN-1:0]           addr;
    logic [XLEN-1:0]           store_data;
    logic [XLEN-1:0]           reg_data;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic                      reg_write;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  entry_t                   push_entry;
  entry_t                   head;
  logic [ENTRY_W-1:0]       head_bits;
  logic [CNT_W-1:0]         count;
  logic [DEPTH*ENTRY_W-1:0] all_entries;
  logic [DEPTH-1:0]         slot_valid;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic                     issue;
  logic                     head_valid;
  logic                     head_is_load;
  logic                     head_is_store;

  lsq_state_e               state, state_nx;

  logic                      wb_en_nx;
  logic [XLEN-1:0]           wb_data_nx;
  logic [XLEN-1:0]           load_data;
  logic [7:0]                byte_lane;
  logic [15:0]               half_lane;

  logic                      wb_en_p1;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_p1;
  logic [XLEN-1:0]           wb_data_p1;
  logic                      wb_load_p1;
  logic                      misaligned_p1;

  entry_t                    slot;
  logic                      stall;
  logic                      unused_slot;

  // No pop bypass: a full queue refuses pushes even when the head retires.
  assign o_Ex_Ready = count < CNT_W'(DEPTH);
  assign push       = i_Ex_Valid & o_Ex_Ready;

  assign push_entry = '{ls_type:    i_Ex_Ls_Type,
                        addr:       i_Ex_Addr,
                        store_data: i_Ex_Store_Data,
                        reg_data:   i_Ex_Reg_Data,
                        reg_addr:   i_Ex_Reg_Addr,
                        reg_write:  i_Ex_Reg_Write};

  cpu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .push       (push),
    .push_data  (ENTRY_W'(push_entry)),
    .pop        (pop),
    .head_data  (head_bits),
    .count      (count),
    .all_data   (all_entries),
    .slot_valid (slot_valid)
  );

  assign head          = entry_t'(head_bits);
  assign head_valid    = count != '0;
  assign head_is_load  = is_load(head.ls_type);
  assign head_is_store = is_store(head.ls_type);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= LSQ_IDLE;
    else         state <= state_nx;
  end

  // IDLE presents a well-formed access straight away so an always-ready
  // memory sees it the cycle after push; REQ holds it while memory stalls.
  always_comb begin
    state_nx      = state;
    pop           = 1'b0;
    drop          = 1'b0;
    issue         = 1'b0;
    mem.req_valid = 1'b0;
    case (state)
      LSQ_IDLE: begin
        if (head_valid) begin
          if (head.ls_type == LS_TYPE_NONE) begin
            pop = 1'b1;
          end else if (is_misaligned(head.ls_type, head.addr[1:0])) begin
            pop  = 1'b1;
            drop = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
      end
      LSQ_REQ:      issue = 1'b1;
      LSQ_WAIT_RSP: begin
        if (mem.rsp_valid) begin
          pop      = 1'b1;
          state_nx = LSQ_IDLE;
        end
      end
      default:      state_nx = LSQ_IDLE;
    endcase

    if (issue) begin
      mem.req_valid = 1'b1;
      if (mem.req_ready) begin
        if (head_is_store) begin
          pop      = 1'b1;
          state_nx = LSQ_IDLE;
        end else begin
          state_nx = LSQ_WAIT_RSP;
        end
      end else begin
        state_nx = LSQ_REQ;
      end
    end
  end

  // Request fields come straight from the head entry, so they stay stable
  // for as long as the head is waiting for acceptance.
  assign mem.write = head_is_store;
  assign mem.addr  = {head.addr[XLEN-1:2], 2'b00};

  always_comb begin
    mem.wdata = head.store_data;
    mem.wstrb = 4'b0000;
    case (head.ls_type)
      LS_TYPE_SB: begin
        mem.wdata = head.store_data << {head.addr[1:0], 3'b000};
        mem.wstrb = 4'b0001 << head.addr[1:0];
      end
      LS_TYPE_SH: begin
        mem.wdata = head.store_data << {head.addr[1], 4'b0000};
        mem.wstrb = 4'b0011 << head.addr[1:0];
      end
      LS_TYPE_SW: begin
        mem.wdata = head.store_data;
        mem.wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  assign byte_lane = mem.rsp_data[{head.addr[1:0], 3'b000} +: 8];
  assign half_lane = head.addr[1] ? mem.rsp_data[31:16] : mem.rsp_data[15:0];

  always_comb begin
    load_data = mem.rsp_data;
    case (head.ls_type)
      LS_TYPE_LB:  load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LS_TYPE_LBU: load_data = {{(XLEN-8){1'b0}}, byte_lane};
      LS_TYPE_LH:  load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
      LS_TYPE_LHU: load_data = {{(XLEN-16){1'b0}}, half_lane};
      default:     load_data = mem.rsp_data;
    endcase
  end

  assign wb_en_nx   = pop & ~drop & ~head_is_store & head.reg_write &
                      (head.reg_addr != '0);
  assign wb_data_nx = head_is_load ? load_data : head.reg_data;

  // ---- p1: writeback register ----
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wb_en_p1      <= 1'b0;
      wb_addr_p1    <= '0;
      wb_data_p1    <= '0;
      wb_load_p1    <= 1'b0;
      misaligned_p1 <= 1'b0;
    end else begin
      wb_en_p1      <= wb_en_nx;
      wb_load_p1    <= wb_en_nx & head_is_load;
      misaligned_p1 <= drop;
      if (wb_en_nx) begin
        wb_addr_p1 <= head.reg_addr;
        wb_data_p1 <= wb_data_nx;
      end
    end
  end

  assign o_Wb_Enable  = wb_en_p1;
  assign o_Wb_Addr    = wb_addr_p1;
  assign o_Wb_Data    = wb_data_p1;
  assign o_Misaligned = misaligned_p1;
  assign o_Empty      = (count == '0) & ~wb_en_p1;

  // A load's value is unavailable until it leaves the writeback register,
  // so both queued loads and a load sitting in p1 block dependent decode.
  always_comb begin
    stall = wb_load_p1 & wb_en_p1 &
            ((wb_addr_p1 == i_Rs_1) | (wb_addr_p1 == i_Rs_2));
    slot  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = entry_t'(all_entries[i*ENTRY_W +: ENTRY_W]);
      if (slot_valid[i] && is_load(slot.ls_type) && (slot.reg_addr != '0) &&
          ((slot.reg_addr == i_Rs_1) || (slot.reg_addr == i_Rs_2)))
        stall = 1'b1;
    end
  end

  assign o_Load_Use_Stall = stall;
  assign unused_slot      = ^{slot.addr, slot.store_data, slot.reg_data, slot.reg_write};

endmodule
